pixel_word_packer: RTL

Packs an 8-bit pixel stream into 32-bit words for return to the host over the same valid/stall word interface the DE1-SoC adapter uses on its input side. It sits between the image pipeline's pixel output and the HPS-facing 32-bit output port. Frame ends are marked by `in_last`: a partial final word is padded and tagged, and an optional trailer word reports the frame byte count.

---
 rtl/pixel_word_packer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pixel_word_packer.sv
// pixel_word_packer
//
// Packs an 8-bit pixel stream into 32-bit words. The first byte of each word lands in
// out_data[7:0]. A frame ends with in_last. A partial final word is filled with PAD in its
// unused upper lanes and completes early.
//
// Optional feature, enabled by defining PIXEL_PACKER_TRAILER_EN:
//   After the final data word of a frame, a trailer word {8'hA5, byte_count} is emitted.
//   Only the trailer word carries out_last=1. byte_count is 24 bits and saturates.
//   With the macro undefined, out_last is set on the final data word instead.
//
// Parameters:
//   PAD              fill byte for the unused lanes of a partial final word
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-high
//   in_data          pixel byte
//   in_valid         in_data / in_last valid this cycle
//   in_last          this byte ends the frame
//   upstream_stall   packer cannot accept a byte this cycle (combinational)
//   out_data         packed word, held stable while stalled
//   out_valid        out_data holds a word
//   out_last         this word ends the frame
//   downstream_stall consumer cannot take a word this cycle

module pixel_word_packer #(
    parameter logic [7:0] PAD = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        upstream_stall,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        downstream_stall
);

`ifdef PIXEL_PACKER_TRAILER_EN
    typedef enum logic [0:0] {StAccum, StTrailer} state_e;
`else
    typedef enum logic [0:0] {StAccum} state_e;
`endif

    state_e      state_q;
    logic [23:0] acc_q;
    logic [1:0]  cnt_q;
`ifdef PIXEL_PACKER_TRAILER_EN
    logic [23:0] count_q;
`endif

    logic        can_load;
    logic        completes;
    logic        accept;
    logic [31:0] packed_word;

    // The output register is free when empty or when its word leaves this cycle.
    assign can_load  = !out_valid || !downstream_stall;
    assign completes = (cnt_q == 2'd3) || in_last;

    // Only a word-completing byte needs the output register, so non-completing bytes
    // keep flowing into the accumulator while the output is stalled.
    assign upstream_stall = (out_valid && downstream_stall && completes) ||
                            (state_q != StAccum);
    assign accept = in_valid && !upstream_stall;

    // Merge the incoming byte at lane cnt_q and pad every lane above it.
    always_comb begin
        packed_word = {PAD, PAD, PAD, PAD};
        unique case (cnt_q)
            2'd0: packed_word = {PAD, PAD, PAD, in_data};
            2'd1: packed_word = {PAD, PAD, in_data, acc_q[7:0]};
            2'd2: packed_word = {PAD, in_data, acc_q[15:0]};
            2'd3: packed_word = {in_data, acc_q};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StAccum;
            acc_q     <= 24'h0;
            cnt_q     <= 2'd0;
            out_data  <= 32'h0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef PIXEL_PACKER_TRAILER_EN
            count_q   <= 24'h0;
`endif
        end else begin
            // A transfer empties the register unless a load below overrides it.
            if (out_valid && !downstream_stall) begin
                out_valid <= 1'b0;
            end

            case (state_q)
                StAccum: begin
                    if (accept) begin
`ifdef PIXEL_PACKER_TRAILER_EN
                        if (count_q != 24'hFFFFFF) begin
                            count_q <= count_q + 24'd1;
                        end
`endif
                        if (completes) begin
                            // The stall term above guarantees can_load here.
                            out_data  <= packed_word;
                            out_valid <= 1'b1;
                            cnt_q     <= 2'd0;
`ifdef PIXEL_PACKER_TRAILER_EN
                            out_last  <= 1'b0;
                            if (in_last) begin
                                state_q <= StTrailer;
                            end
`else
                            out_last  <= in_last;
`endif
                        end else begin
                            unique case (cnt_q)
                                2'd0:    acc_q[7:0]   <= in_data;
                                2'd1:    acc_q[15:8]  <= in_data;
                                2'd2:    acc_q[23:16] <= in_data;
                                default: acc_q        <= acc_q;
                            endcase
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
`ifdef PIXEL_PACKER_TRAILER_EN
                StTrailer: begin
                    if (can_load) begin
                        out_data  <= {8'hA5, count_q};
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        count_q   <= 24'h0;
                        state_q   <= StAccum;
                    end
                end
`endif
                default: state_q <= StAccum;
            endcase
        end
    end

endmodule
